// File: rtl/decode_stage_if.sv
// Handshake and decoded-payload bundle between fetch, the decode stage and register-read.
// master drives instructions in and consumes payload; slave is the decode stage itself.
interface decode_stage_if #(
    parameter int IMM_W    = 32,
    parameter int REG_BITS = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_inst;
    logic                out_valid;
    logic                out_ready;
    logic [6:0]          opcode;
    logic [REG_BITS-1:0] rd;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [IMM_W-1:0]    imm;
    logic [2:0]          fmt;
    logic                illegal;

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, fmt, illegal
    );

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, fmt, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32 decode stage: field extraction, immediate generation, format
// classification and illegal detection, with an optional 2-entry skid buffer and flush.
module decode_stage #(
    parameter int IMM_W    = 32,
    parameter int REG_BITS = 5,
    parameter bit SKID     = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    decode_stage_if.slave bus
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [6:0]          opcode;
        logic [REG_BITS-1:0] rd;
        logic [REG_BITS-1:0] rs1;
        logic [REG_BITS-1:0] rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [IMM_W-1:0]    imm;
        logic [2:0]          fmt;
        logic                illegal;
    } payload_t;

    logic [31:0]        inst;
    logic [2:0]         fmt_raw;
    logic               uses_rd;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               reg_bad;
    logic               ill;
    logic signed [31:0] imm32;
    payload_t           dec;

    assign inst = bus.in_inst;

    // Every listed opcode ends in 2'b11, so a compressed-quadrant word also lands on FMT_ILL.
    always_comb begin
        fmt_raw = FMT_ILL;
        case (inst[6:0])
            7'b0110011: fmt_raw = FMT_R;
            7'b0000011, 7'b0010011, 7'b1100111,
            7'b1110011, 7'b0001111: fmt_raw = FMT_I;
            7'b0100011: fmt_raw = FMT_S;
            7'b1100011: fmt_raw = FMT_B;
            7'b0110111, 7'b0010111: fmt_raw = FMT_U;
            7'b1101111: fmt_raw = FMT_J;
            default:    fmt_raw = FMT_ILL;
        endcase
        if (inst[1:0] != 2'b11) begin
            fmt_raw = FMT_ILL;
        end
    end

    always_comb begin
        uses_rd  = (fmt_raw == FMT_R) || (fmt_raw == FMT_I) || (fmt_raw == FMT_U) || (fmt_raw == FMT_J);
        uses_rs1 = (fmt_raw == FMT_R) || (fmt_raw == FMT_I) || (fmt_raw == FMT_S) || (fmt_raw == FMT_B);
        uses_rs2 = (fmt_raw == FMT_R) || (fmt_raw == FMT_S) || (fmt_raw == FMT_B);
        // RV32E only has x0..x15: bit 4 of any register field the format reads is an error.
        reg_bad  = (REG_BITS == 4) &&
                   ((uses_rd && inst[11]) || (uses_rs1 && inst[19]) || (uses_rs2 && inst[24]));
        ill      = (fmt_raw == FMT_ILL) || reg_bad;
    end

    always_comb begin
        imm32 = '0;
        case (fmt_raw)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'b0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.opcode  = inst[6:0];
        dec.rd      = inst[7 +: REG_BITS];
        dec.rs1     = inst[15 +: REG_BITS];
        dec.rs2     = inst[20 +: REG_BITS];
        dec.funct3  = inst[14:12];
        dec.funct7  = inst[31:25];
        // Size cast of a signed value sign-extends to the full immediate width.
        dec.imm     = ill ? '0 : IMM_W'(imm32);
        dec.fmt     = ill ? FMT_ILL : fmt_raw;
        dec.illegal = ill;
    end

    payload_t out_reg;
    payload_t out_next;
    payload_t skid_reg;
    payload_t skid_next;
    logic     out_valid_reg;
    logic     out_valid_next;
    logic     skid_valid_reg;
    logic     skid_valid_next;
    logic     in_ready;
    logic     in_xfer;
    logic     out_free;

    assign in_xfer  = bus.in_valid && in_ready;
    assign out_free = !out_valid_reg || bus.out_ready;

    // The skid entry only fills while the output register is stalled; it always drains first.
    always_comb begin
        out_next        = out_reg;
        out_valid_next  = out_valid_reg;
        skid_next       = skid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (out_free) begin
            if (skid_valid_reg) begin
                out_next        = skid_reg;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end else begin
                out_valid_next = in_xfer;
                if (in_xfer) begin
                    out_next = dec;
                end
            end
        end else if (in_xfer) begin
            skid_next       = dec;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_reg        <= '0;
            out_valid_reg  <= 1'b0;
            skid_reg       <= '0;
            skid_valid_reg <= 1'b0;
        end else begin
            out_reg        <= out_next;
            out_valid_reg  <= out_valid_next;
            skid_reg       <= skid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic in_ready_reg;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    in_ready_reg <= 1'b1;
                end else begin
                    in_ready_reg <= !skid_valid_next;
                end
            end

            assign in_ready = in_ready_reg;
        end else begin : g_noskid
            // Without a skid entry the stage can only accept when its register frees up.
            assign in_ready = out_free;
        end
    endgenerate

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.opcode    = out_reg.opcode;
    assign bus.rd        = out_reg.rd;
    assign bus.rs1       = out_reg.rs1;
    assign bus.rs2       = out_reg.rs2;
    assign bus.funct3    = out_reg.funct3;
    assign bus.funct7    = out_reg.funct7;
    assign bus.imm       = out_reg.imm;
    assign bus.fmt       = out_reg.fmt;
    assign bus.illegal   = out_reg.illegal;
endmodule
